// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: states, ALU codes,
// datapath select values and the opcodes the decoder recognises.
package control_pkg;

  localparam logic [3:0] ST_FETCH     = 4'd0;
  localparam logic [3:0] ST_DECODE    = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
  localparam logic [3:0] ST_MEM_READ  = 4'd3;
  localparam logic [3:0] ST_MEM_WB    = 4'd4;
  localparam logic [3:0] ST_MEM_WRITE = 4'd5;
  localparam logic [3:0] ST_EXEC_R    = 4'd6;
  localparam logic [3:0] ST_EXEC_I    = 4'd7;
  localparam logic [3:0] ST_ALU_WB    = 4'd8;
  localparam logic [3:0] ST_BRANCH    = 4'd9;
  localparam logic [3:0] ST_JALR_ADDR = 4'd10;
  localparam logic [3:0] ST_JUMP      = 4'd11;
  localparam logic [3:0] ST_HALT      = 4'd12;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_AND     = 4'b0010;
  localparam logic [3:0] ALU_OR      = 4'b0011;
  localparam logic [3:0] ALU_XOR     = 4'b0100;
  localparam logic [3:0] ALU_SLT     = 4'b0101;
  localparam logic [3:0] ALU_SLTU    = 4'b0110;
  localparam logic [3:0] ALU_SLL     = 4'b0111;
  localparam logic [3:0] ALU_SRL     = 4'b1000;
  localparam logic [3:0] ALU_SRA     = 4'b1001;
  localparam logic [3:0] ALU_INVALID = 4'b1111;

  typedef enum logic [1:0] {SRC_A_PC, SRC_A_OLD_PC, SRC_A_RS1, SRC_A_ZERO} src_a_t;
  typedef enum logic [1:0] {SRC_B_RS2, SRC_B_IMM, SRC_B_FOUR} src_b_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_t;
  typedef enum logic [1:0] {WB_ALU_RESULT, WB_MEM_DATA, WB_ALU_OUT} wb_t;
  typedef enum logic [1:0] {CLS_OTHER, CLS_R, CLS_I, CLS_BRANCH} op_class_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational func3/func7 decode to an ALU operation for register, immediate
// and branch instructions, flagging encodings that are not part of RV32I.
module alu_decoder
  import control_pkg::*;
(
  input  op_class_t   op_class,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  output logic [3:0]  alu_control,
  output logic        illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (op_class)
      CLS_R, CLS_I: begin
        case (func3)
          3'b000: alu_control = (op_class == CLS_R && func7[5]) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control = ALU_SLL;
          3'b010: alu_control = ALU_SLT;
          3'b011: alu_control = ALU_SLTU;
          3'b100: alu_control = ALU_XOR;
          3'b101: alu_control = func7[5] ? ALU_SRA : ALU_SRL;
          3'b110: alu_control = ALU_OR;
          3'b111: alu_control = ALU_AND;
        endcase
        // For OP-IMM the upper bits are immediate data except on the shifts.
        if (op_class == CLS_R)
          illegal = !((func7 == 7'h00) ||
                      (func7 == 7'h20 && (func3 == 3'b000 || func3 == 3'b101)));
        else if (func3 == 3'b001)
          illegal = (func7 != 7'h00);
        else if (func3 == 3'b101)
          illegal = (func7 != 7'h00) && (func7 != 7'h20);
      end
      CLS_BRANCH: begin
        case (func3[2:1])
          2'b00: alu_control = ALU_SUB;
          2'b01: begin
            alu_control = ALU_INVALID;
            illegal     = 1'b1;
          end
          2'b10: alu_control = ALU_SLT;
          2'b11: alu_control = ALU_SLTU;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback over a
// shared memory port with a ready handshake; outputs are forced idle during rst.
module multicycle_control
  import control_pkg::*;
#(
  parameter bit WAIT_FOR_MEM    = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       mem_addr_source,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_source,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic [2:0] imm_source,
  output logic [1:0] write_back_source,
  output logic       illegal_instr,
  output logic [3:0] dbg_state
);

  logic [3:0] state, state_next;
  op_class_t  op_class;
  logic [3:0] dec_alu;
  logic       dec_illegal, bad_instr, mem_rdy, br_taken;

  assign mem_rdy   = WAIT_FOR_MEM ? mem_ready : 1'b1;
  assign dbg_state = state;
  // BEQ/BNE test equality directly; the SLT-based compares invert the sense.
  assign br_taken  = func3[0] ^ (func3[2] ? !alu_zero : alu_zero);

  always_comb begin
    case (op)
      OP_R:      op_class = CLS_R;
      OP_IMM:    op_class = CLS_I;
      OP_BRANCH: op_class = CLS_BRANCH;
      default:   op_class = CLS_OTHER;
    endcase
  end

  alu_decoder u_alu_decoder (
    .op_class    (op_class),
    .func3       (func3),
    .func7       (func7),
    .alu_control (dec_alu),
    .illegal     (dec_illegal)
  );

  always_comb begin
    case (op)
      OP_LOAD:                 bad_instr = (func3 == 3'b011) || (func3[2:1] == 2'b11);
      OP_STORE:                bad_instr = func3[2] || (func3 == 3'b011);
      OP_JALR:                 bad_instr = (func3 != 3'b000);
      OP_R, OP_IMM, OP_BRANCH: bad_instr = dec_illegal;
      OP_LUI, OP_AUIPC, OP_JAL: bad_instr = 1'b0;
      default:                 bad_instr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next        = state;
    mem_req           = 1'b0;
    mem_write         = 1'b0;
    mem_addr_source   = 1'b0;
    ir_write          = 1'b0;
    pc_write          = 1'b0;
    pc_source         = 1'b0;
    reg_write         = 1'b0;
    alu_src_a         = SRC_A_PC;
    alu_src_b         = SRC_B_RS2;
    alu_control       = ALU_ADD;
    imm_source        = IMM_I;
    write_back_source = WB_ALU_RESULT;
    illegal_instr     = 1'b0;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRC_B_FOUR;
          if (mem_rdy) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = ST_DECODE;
          end
        end
        ST_DECODE: begin
          alu_src_a  = SRC_A_OLD_PC;
          alu_src_b  = SRC_B_IMM;
          imm_source = (op == OP_JAL) ? IMM_J : IMM_B;
          if (bad_instr)
            state_next = TRAP_ON_ILLEGAL ? ST_HALT : ST_FETCH;
          else begin
            case (op)
              OP_LOAD, OP_STORE:       state_next = ST_MEM_ADDR;
              OP_R:                    state_next = ST_EXEC_R;
              OP_IMM, OP_LUI, OP_AUIPC: state_next = ST_EXEC_I;
              OP_BRANCH:               state_next = ST_BRANCH;
              OP_JAL:                  state_next = ST_JUMP;
              OP_JALR:                 state_next = ST_JALR_ADDR;
              default:                 state_next = ST_FETCH;
            endcase
          end
        end
        ST_MEM_ADDR: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_IMM;
          imm_source = (op == OP_STORE) ? IMM_S : IMM_I;
          state_next = (op == OP_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
        end
        ST_MEM_READ, ST_MEM_WRITE: begin
          mem_req         = 1'b1;
          mem_addr_source = 1'b1;
          mem_write       = (state == ST_MEM_WRITE);
          if (mem_rdy) state_next = (state == ST_MEM_WRITE) ? ST_FETCH : ST_MEM_WB;
        end
        ST_MEM_WB: begin
          reg_write         = 1'b1;
          write_back_source = WB_MEM_DATA;
          state_next        = ST_FETCH;
        end
        ST_EXEC_R: begin
          alu_src_a   = SRC_A_RS1;
          alu_control = dec_alu;
          state_next  = ST_ALU_WB;
        end
        ST_EXEC_I: begin
          alu_src_b  = SRC_B_IMM;
          state_next = ST_ALU_WB;
          case (op)
            OP_LUI: begin
              alu_src_a  = SRC_A_ZERO;
              imm_source = IMM_U;
            end
            OP_AUIPC: begin
              alu_src_a  = SRC_A_OLD_PC;
              imm_source = IMM_U;
            end
            default: begin
              alu_src_a   = SRC_A_RS1;
              alu_control = dec_alu;
            end
          endcase
        end
        ST_ALU_WB: begin
          reg_write         = 1'b1;
          write_back_source = WB_ALU_OUT;
          state_next        = ST_FETCH;
        end
        ST_BRANCH: begin
          alu_src_a   = SRC_A_RS1;
          alu_control = dec_alu;
          pc_write    = br_taken;
          pc_source   = br_taken;
          state_next  = ST_FETCH;
        end
        ST_JALR_ADDR: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_IMM;
          state_next = ST_JUMP;
        end
        ST_JUMP: begin
          alu_src_a  = SRC_A_OLD_PC;
          alu_src_b  = SRC_B_FOUR;
          reg_write  = 1'b1;
          pc_write   = 1'b1;
          pc_source  = 1'b1;
          state_next = ST_FETCH;
        end
        ST_HALT: illegal_instr = 1'b1;
        default: state_next = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised instruction stream against a per-instruction cycle-script model;
// one instance with memory waits and trapping, one single-cycle non-trapping.
module tb_multicycle_control;

  typedef struct packed {
    logic mem_req, mem_write, mas, ir_write, pc_write, pc_source, reg_write;
    logic [1:0] a, b;
    logic [3:0] alu;
    logic [2:0] imm;
    logic [1:0] wb;
    logic       ill;
  } out_t;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011;
  localparam logic [6:0] OPIMM = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] BRANCH = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, alu_zero, mem_ready;
  logic [6:0] op, func7;
  logic [2:0] func3;

  logic mr_a, mw_a, mas_a, irw_a, pcw_a, pcs_a, rw_a, ill_a;
  logic mr_b, mw_b, mas_b, irw_b, pcw_b, pcs_b, rw_b, ill_b;
  logic [1:0] sa_a, sb_a, wb_a, sa_b, sb_b, wb_b;
  logic [3:0] alu_a, st_a, alu_b, st_b;
  logic [2:0] imm_a, imm_b;
  logic [21:0] obs_a, obs_b, obs;
  logic use_b, cur_wait, cur_trap;

  assign obs_a = {mr_a, mw_a, mas_a, irw_a, pcw_a, pcs_a, rw_a, sa_a, sb_a, alu_a, imm_a, wb_a, ill_a};
  assign obs_b = {mr_b, mw_b, mas_b, irw_b, pcw_b, pcs_b, rw_b, sa_b, sb_b, alu_b, imm_b, wb_b, ill_b};
  assign obs   = use_b ? obs_b : obs_a;

  multicycle_control dut_a (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mr_a), .mem_write(mw_a), .mem_addr_source(mas_a),
    .ir_write(irw_a), .pc_write(pcw_a), .pc_source(pcs_a), .reg_write(rw_a),
    .alu_src_a(sa_a), .alu_src_b(sb_a), .alu_control(alu_a), .imm_source(imm_a),
    .write_back_source(wb_a), .illegal_instr(ill_a), .dbg_state(st_a)
  );

  multicycle_control #(.WAIT_FOR_MEM(1'b0), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mr_b), .mem_write(mw_b), .mem_addr_source(mas_b),
    .ir_write(irw_b), .pc_write(pcw_b), .pc_source(pcs_b), .reg_write(rw_b),
    .alu_src_a(sa_b), .alu_src_b(sb_b), .alu_control(alu_b), .imm_source(imm_b),
    .write_back_source(wb_b), .illegal_instr(ill_b), .dbg_state(st_b)
  );

  logic [21:0] exp_q[$];
  logic        rdy_q[$];
  int n_checks = 0;
  int n_errors = 0;
  string cur_tag;

  task automatic check_eq(input string tag, input logic [21:0] got, input logic [21:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic legal(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    case (o)
      LOAD:   return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      STORE:  return f3 inside {3'd0, 3'd1, 3'd2};
      RTYPE:  return (f7 == 7'h00) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
      OPIMM:  return (f3 == 3'd1) ? (f7 == 7'h00) :
                     (f3 == 3'd5) ? (f7 inside {7'h00, 7'h20}) : 1'b1;
      LUI, AUIPC, JAL: return 1'b1;
      JALR:   return f3 == 3'd0;
      BRANCH: return !(f3 inside {3'd2, 3'd3});
      default: return 1'b0;
    endcase
  endfunction

  // ALU codes: ADD 0 SUB 1 AND 2 OR 3 XOR 4 SLT 5 SLTU 6 SLL 7 SRL 8 SRA 9
  function automatic logic [3:0] exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    if (o == BRANCH) return (f3[2] == 1'b0) ? 4'd1 : (f3[1] ? 4'd6 : 4'd5);
    case (f3)
      3'd0: return (o == RTYPE && f7[5]) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7[5] ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z);
    case (f3)
      3'd0: return z;    // BEQ
      3'd1: return !z;   // BNE
      3'd4: return !z;   // BLT: rs1<rs2 gives SLT=1
      3'd5: return z;    // BGE
      3'd6: return !z;   // BLTU
      default: return z; // BGEU
    endcase
  endfunction

  function automatic logic dc();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input out_t e, input logic r);
    exp_q.push_back(e);
    rdy_q.push_back(r);
  endtask

  task automatic run(input int n);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < n) begin
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      check_eq(cur_tag, obs, exp_q.pop_front());
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic reset_both();
    rst = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("reset_outputs", obs, '0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  // Script of expected outputs for one instruction, cycle by cycle.
  task automatic gen_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input int nf_in, input int nm_in);
    out_t e, wb;
    int nf, nm;
    nf = (nf_in >= 0) ? nf_in : (cur_wait ? $urandom_range(0, 2) : 0);
    nm = (nm_in >= 0) ? nm_in : (cur_wait ? $urandom_range(0, 2) : 0);
    e = '0; e.mem_req = 1; e.b = 2'b10;
    for (int i = 0; i < nf; i++) push(e, 1'b0);
    e.ir_write = 1; e.pc_write = 1;
    push(e, cur_wait ? 1'b1 : dc());
    e = '0; e.a = 2'b01; e.b = 2'b01; e.imm = (o == JAL) ? 3'd3 : 3'd2;
    push(e, dc());
    if (!legal(o, f3, f7)) return;
    wb = '0; wb.reg_write = 1; wb.wb = 2'b10;
    e = '0;
    case (o)
      LOAD, STORE: begin
        e.a = 2'b10; e.b = 2'b01; e.imm = (o == STORE) ? 3'd1 : 3'd0;
        push(e, dc());
        e = '0; e.mem_req = 1; e.mas = 1; e.mem_write = (o == STORE);
        for (int i = 0; i < nm; i++) push(e, 1'b0);
        push(e, cur_wait ? 1'b1 : dc());
        if (o == LOAD) begin
          e = '0; e.reg_write = 1; e.wb = 2'b01;
          push(e, dc());
        end
      end
      RTYPE: begin
        e.a = 2'b10; e.alu = exp_alu(o, f3, f7);
        push(e, dc()); push(wb, dc());
      end
      OPIMM: begin
        e.a = 2'b10; e.b = 2'b01; e.alu = exp_alu(o, f3, f7);
        push(e, dc()); push(wb, dc());
      end
      LUI, AUIPC: begin
        e.a = (o == LUI) ? 2'b11 : 2'b01; e.b = 2'b01; e.imm = 3'd4;
        push(e, dc()); push(wb, dc());
      end
      BRANCH: begin
        e.a = 2'b10; e.alu = exp_alu(o, f3, f7);
        e.pc_write = taken(f3, z); e.pc_source = taken(f3, z);
        push(e, dc());
      end
      default: begin
        if (o == JALR) begin
          e.a = 2'b10; e.b = 2'b01;
          push(e, dc());
        end
        e = '0; e.a = 2'b01; e.b = 2'b10; e.reg_write = 1; e.pc_write = 1; e.pc_source = 1;
        push(e, dc());
      end
    endcase
  endtask

  task automatic do_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                          input logic z, input int nf, input int nm);
    out_t e;
    op = o; func3 = f3; func7 = f7; alu_zero = z;
    cur_tag = $sformatf("%s_op%b_f3%0d_f7%h", use_b ? "b" : "a", o, f3, f7);
    gen_instr(o, f3, f7, z, nf, nm);
    run(1000);
    if (cur_trap && !legal(o, f3, f7)) begin
      e = '0; e.ill = 1;
      for (int i = 0; i < 4; i++) push(e, dc());
      cur_tag = "halt";
      run(1000);
      reset_both();
    end
  endtask

  task automatic rand_instr();
    logic [6:0] ops [12];
    logic [6:0] f7;
    ops = '{LOAD, STORE, RTYPE, OPIMM, LUI, AUIPC, BRANCH, JAL, JALR,
            7'b1110011, 7'b0001111, 7'b0000000};
    case ($urandom_range(0, 2))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = 7'($urandom_range(0, 127));
    endcase
    do_instr(ops[($urandom_range(0, 20) == 0) ? $urandom_range(9, 11) : $urandom_range(0, 8)],
             3'($urandom_range(0, 7)), f7, dc(), -1, -1);
  endtask

  initial begin
    rst = 1'b1; op = '0; func3 = '0; func7 = '0; alu_zero = 1'b0; mem_ready = 1'b0;
    use_b = 1'b0; cur_wait = 1'b1; cur_trap = 1'b1;
    reset_both();

    do_instr(RTYPE, 3'd0, 7'h20, 1'b0, 0, 0);   // SUB: reg_write in cycle 4
    do_instr(LOAD, 3'd2, 7'h00, 1'b0, 0, 3);    // LW with 3 stall cycles
    do_instr(BRANCH, 3'd1, 7'h00, 1'b0, 0, 0);  // BNE taken
    do_instr(BRANCH, 3'd5, 7'h00, 1'b0, 0, 0);  // BGE not taken
    do_instr(JALR, 3'd0, 7'h00, 1'b0, 0, 0);
    do_instr(JAL, 3'd0, 7'h00, 1'b0, 1, 0);
    do_instr(STORE, 3'd2, 7'h00, 1'b0, 2, 1);
    do_instr(7'b1110011, 3'd0, 7'h00, 1'b0, 0, 0);

    // Reset while a store is stalled in MEM_WRITE.
    op = STORE; func3 = 3'd0; func7 = 7'h00;
    cur_tag = "store_pre_rst";
    gen_instr(STORE, 3'd0, 7'h00, 1'b0, 0, 3);
    run(4);
    exp_q.delete();
    rdy_q.delete();
    rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    check_eq("rst_mem_req", 22'(mr_a), 22'd0);
    check_eq("rst_mem_write", 22'(mw_a), 22'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_fetch_req", 22'(mr_a), 22'd1);
    check_eq("post_rst_no_irw", 22'(irw_a), 22'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) rand_instr();

    use_b = 1'b1; cur_wait = 1'b0; cur_trap = 1'b0;
    reset_both();
    do_instr(7'b1110011, 3'd0, 7'h00, 1'b0, 0, 0);
    do_instr(LOAD, 3'd0, 7'h00, 1'b0, 0, 0);
    for (int i = 0; i < 100; i++) rand_instr();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
